// File: rtl/mux_sel_sched.sv
// mux_sel_sched
//   Drives the select bus of a mux_set array during one sweep. On an accepted
//   start it emits CYC valid select vectors, where mux m selects
//   (base + m*stride) mod N and base advances by one per valid beat.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      begin a sweep (honoured only while idle)
//   offset_in  initial base, reduced mod N on an accepted start
//   stride_in  per-mux stride, reduced mod N on an accepted start
//   stall      freezes the sweep while high
//   sel        per-mux select to mux_set
//   sel_valid  sel carries a counted beat this cycle
//   busy       sweep in progress
//   done       one-cycle pulse after the last beat
//   beat_cnt   beats issued in the current sweep
module mux_sel_sched #(
  parameter int unsigned N   = 4,
  parameter int unsigned M   = 3,
  parameter int unsigned CYC = 4,
  parameter int unsigned SW  = $clog2(N) - ((N != 1) ? 1 : 0) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [SW-1:0]              offset_in,
  input  logic [SW-1:0]              stride_in,
  input  logic                       stall,
  output logic [SW-1:0]              sel [M-1:0],
  output logic                       sel_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(CYC+1)-1:0]   beat_cnt
);

  localparam int unsigned CW = $clog2(CYC + 1);
  localparam logic [CW-1:0] CYC_C = CW'(CYC);
  localparam logic [SW-1:0] NM1_C = SW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [SW-1:0]   r_base;
  logic [SW-1:0]   r_stride;
  logic [SW-1:0]   r_sel [M-1:0];
  logic            r_sel_valid;
  logic [CW-1:0]   r_beat_cnt;

  logic            w_accept;
  logic            w_beat;
  logic            w_issue;
  logic [SW-1:0]   w_off_mod;
  logic [SW-1:0]   w_str_mod;
  logic [SW-1:0]   w_issue_base;
  logic [SW-1:0]   w_issue_stride;
  logic [SW-1:0]   w_base_inc;
  logic [SW-1:0]   w_sel_nxt [M-1:0];

  // Reduce (not truncate) the captured operands; N need not be a power of 2.
  assign w_off_mod = SW'(32'(offset_in) % N);
  assign w_str_mod = SW'(32'(stride_in) % N);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_beat_cnt == CYC_C) begin
          w_state_nxt = S_DONE;
        end else if (!stall) begin
          w_beat = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat generation
  // The first beat is issued on the accepting edge straight from the reduced
  // inputs, which gives the one-cycle start-to-first-beat latency; later beats
  // use the stored base/stride.
  // ---------------------------------------------------------------------------
  assign w_issue        = w_accept | w_beat;
  assign w_issue_base   = w_accept ? w_off_mod : r_base;
  assign w_issue_stride = w_accept ? w_str_mod : r_stride;
  assign w_base_inc     = (w_issue_base == NM1_C) ? '0 : w_issue_base + SW'(1);

  // Operands are < N and m < M, so the 32-bit sum cannot overflow before mod.
  always_comb begin
    for (int unsigned m = 0; m < M; m++) begin
      w_sel_nxt[m] = SW'((32'(w_issue_base) + m * 32'(w_issue_stride)) % N);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base      <= '0;
      r_stride    <= '0;
      r_sel_valid <= 1'b0;
      r_beat_cnt  <= '0;
      for (int unsigned m = 0; m < M; m++) begin
        r_sel[m] <= '0;
      end
    end else begin
      r_sel_valid <= w_issue;
      if (w_issue) begin
        r_base     <= w_base_inc;
        r_stride   <= w_issue_stride;
        r_beat_cnt <= w_accept ? CW'(1) : r_beat_cnt + CW'(1);
        for (int unsigned m = 0; m < M; m++) begin
          r_sel[m] <= w_sel_nxt[m];
        end
      end else if (r_state == S_DONE) begin
        // Leaving DONE: idle outputs return to zero.
        r_beat_cnt <= '0;
        for (int unsigned m = 0; m < M; m++) begin
          r_sel[m] <= '0;
        end
      end
    end
  end

  assign sel       = r_sel;
  assign sel_valid = r_sel_valid;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_mux_sel_sched.sv
module tb_mux_sel_sched;

  localparam int M = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stall;
  logic [1:0] offset_in, stride_in;

  logic [1:0] selA [M-1:0];
  logic [1:0] selB [M-1:0];
  logic [0:0] selC [M-1:0];
  logic       vA, bA, dA, vB, bB, dB, vC, bC, dC;
  logic [2:0] cA;
  logic [1:0] cB, cC;

  mux_sel_sched #(.N(4), .M(3), .CYC(4)) u_a (
    .clk(clk), .reset(reset), .start(start), .offset_in(offset_in),
    .stride_in(stride_in), .stall(stall), .sel(selA), .sel_valid(vA),
    .busy(bA), .done(dA), .beat_cnt(cA));

  mux_sel_sched #(.N(3), .M(3), .CYC(2)) u_b (
    .clk(clk), .reset(reset), .start(start), .offset_in(offset_in),
    .stride_in(stride_in), .stall(stall), .sel(selB), .sel_valid(vB),
    .busy(bB), .done(dB), .beat_cnt(cB));

  mux_sel_sched #(.N(1), .M(3), .CYC(3)) u_c (
    .clk(clk), .reset(reset), .start(start), .offset_in(offset_in[0:0]),
    .stride_in(stride_in[0:0]), .stall(stall), .sel(selC), .sel_valid(vC),
    .busy(bC), .done(dC), .beat_cnt(cC));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pk(input int a, input int b, input int c);
    return a | (b << 4) | (c << 8);
  endfunction

  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Reference model: sweep phase (0 idle, 1 running, 2 done), captured
  // operands, and number of beats issued; sel follows from arithmetic.
  int pN [3] = '{4, 3, 1};
  int pC [3] = '{4, 2, 3};
  int ph [3], off [3], str [3], iss [3];
  bit val [3];

  task automatic model_step(input bit rs, input bit st, input bit sl, input int o, input int s);
    for (int i = 0; i < 3; i++) begin
      if (rs) begin
        ph[i] = 0; iss[i] = 0; val[i] = 0; off[i] = 0; str[i] = 0;
      end else begin
        case (ph[i])
          0: begin
            if (st) begin
              off[i] = o % pN[i]; str[i] = s % pN[i];
              iss[i] = 1; val[i] = 1; ph[i] = 1;
            end else val[i] = 0;
          end
          1: begin
            if (iss[i] == pC[i]) begin ph[i] = 2; val[i] = 0; end
            else if (!sl) begin iss[i]++; val[i] = 1; end
            else val[i] = 0;
          end
          default: begin ph[i] = 0; iss[i] = 0; val[i] = 0; end
        endcase
      end
    end
  endtask

  function automatic int exp_sel(input int i);
    int v[3];
    for (int m = 0; m < 3; m++)
      v[m] = (ph[i] == 0) ? 0 : (off[i] + iss[i] - 1 + m * str[i]) % pN[i];
    return pk(v[0], v[1], v[2]);
  endfunction

  function automatic int exp_ctl(input int i);
    return (int'(val[i]) << 12) | (int'(ph[i] == 1) << 8) | (int'(ph[i] == 2) << 4) | iss[i];
  endfunction

  function automatic int obs_sel(input int i);
    case (i)
      0: return pk(int'(selA[0]), int'(selA[1]), int'(selA[2]));
      1: return pk(int'(selB[0]), int'(selB[1]), int'(selB[2]));
      default: return pk(int'(selC[0]), int'(selC[1]), int'(selC[2]));
    endcase
  endfunction

  function automatic int obs_ctl(input int i);
    case (i)
      0: return (int'(vA) << 12) | (int'(bA) << 8) | (int'(dA) << 4) | int'(cA);
      1: return (int'(vB) << 12) | (int'(bB) << 8) | (int'(dB) << 4) | int'(cB);
      default: return (int'(vC) << 12) | (int'(bC) << 8) | (int'(dC) << 4) | int'(cC);
    endcase
  endfunction

  task automatic compare_all();
    int s, coll;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sel_%0d", i), obs_sel(i), exp_sel(i));
      check($sformatf("ctl_%0d", i), obs_ctl(i), exp_ctl(i));
      if (val[i] && M <= pN[i] && gcd(str[i], pN[i]) == 1) begin
        s = obs_sel(i);
        coll = 0;
        for (int a = 0; a < 3; a++)
          for (int b = a + 1; b < 3; b++)
            if (((s >> (4 * a)) & 15) == ((s >> (4 * b)) & 15)) coll++;
        check($sformatf("distinct_%0d", i), coll, 0);
      end
    end
  endtask

  task automatic cyc(input bit rs, input bit st, input bit sl, input int o, input int s);
    reset = rs; start = st; stall = sl;
    offset_in = 2'(o); stride_in = 2'(s);
    model_step(rs, st, sl, o, s);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((ph[0] != 0 || ph[1] != 0 || ph[2] != 0) && k < 50) begin
      cyc(0, 0, 0, 0, 0);
      k++;
    end
    check("idle_timeout", k, (k < 50) ? k : -1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; offset_in = '0; stride_in = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_ctlA", obs_ctl(0), 0);
    check("rst_selA", obs_sel(0), 0);

    // offset 2, stride 1
    cyc(0, 1, 0, 2, 1);
    check("tp1_b1", obs_sel(0), pk(2, 3, 0));
    check("tp1_b1_N3", obs_sel(1), pk(2, 0, 1));
    idle(3);
    check("tp1_b4", obs_sel(0), pk(1, 2, 3));
    idle(1);
    check("tp1_done", int'(dA) * 2 + int'(bA), 2);
    wait_idle();

    // offset 0, stride 3
    cyc(0, 1, 0, 0, 3);
    check("tp2_b1", obs_sel(0), pk(0, 3, 2));
    idle(3);
    check("tp2_b4", obs_sel(0), pk(3, 2, 1));
    wait_idle();

    // stall held three cycles after beat 2
    cyc(0, 1, 0, 2, 1);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 0);
      check("tp3_hold", obs_sel(0) | (int'(vA) << 12), pk(3, 0, 1));
    end
    cyc(0, 0, 0, 0, 0);
    check("tp3_resume", obs_sel(0), pk(0, 1, 2));
    wait_idle();

    // start mid-run ignored; later start in idle begins at base 1
    cyc(0, 1, 0, 2, 1);
    cyc(0, 1, 0, 1, 1);
    check("tp4_ignored", obs_sel(0), pk(3, 0, 1));
    wait_idle();
    cyc(0, 1, 0, 1, 1);
    check("tp4_new", obs_sel(0), pk(1, 2, 3));
    wait_idle();

    // reset at beat 2, then a clean sweep
    cyc(0, 1, 0, 2, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("tp5_rst", obs_ctl(0) | obs_sel(0), 0);
    cyc(1, 1, 0, 1, 1);
    check("tp5_rst_wins", obs_ctl(0), 0);
    cyc(0, 1, 0, 3, 2);
    check("tp5_clean", obs_sel(0), pk(3, 1, 3));
    wait_idle();

    // N=3 sweeps on u_b
    cyc(0, 1, 0, 2, 2);
    check("tp6_b1", obs_sel(1), pk(2, 1, 0));
    cyc(0, 0, 0, 0, 0);
    check("tp6_b2", obs_sel(1), pk(0, 2, 1));
    wait_idle();
    cyc(0, 1, 0, 3, 2);
    check("tp6_red_b1", obs_sel(1), pk(0, 2, 1));
    cyc(0, 0, 0, 0, 0);
    check("tp6_red_b2", obs_sel(1), pk(1, 0, 2));
    wait_idle();

    // randomized sweeps
    for (int sw = 0; sw < 40; sw++) begin
      cyc(0, 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3));
      for (int k = 0; k < 25; k++) begin
        cyc($urandom_range(0, 40) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      wait_idle();
      idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
